// File: rtl/pwm_pkg.sv
// Shared definitions for the servo PWM generator and the receive-side width decoder.
package pwm_pkg;

  localparam int unsigned CNT_W_DEF       = 20;
  localparam int unsigned TIMEOUT_DEF     = 1000000;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } meter_state_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_width_meter.sv
// One PWM input channel: synchronizer, edge detect, width/period counters,
// loss-of-signal timeout and a one-deep pending result register.
module pwm_width_meter
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  input  logic             take,
  output logic             pending,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             lost
);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev;
  logic                   rise_q;
  logic                   fall_q;
  meter_state_t           state;
  logic [CNT_W-1:0]       width_cnt;
  logic [CNT_W-1:0]       period_cnt;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain, left unreset so reset can never fabricate an edge.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  // Registered edge detect; s_prev keeps tracking the live level through reset.
  always_ff @(posedge clk) begin
    s_prev <= s;
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= s & ~s_prev;
      fall_q <= ~s & s_prev;
    end
  end

  // Channel FSM with counters, timeout and pending result (freshest publish wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      width_cnt  <= '0;
      period_cnt <= '0;
      pending    <= 1'b0;
      width      <= '0;
      period     <= '0;
      lost       <= 1'b0;
    end else begin
      if (take) begin
        pending <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          width_cnt  <= '0;
          period_cnt <= '0;
          if (rise_q) begin
            state      <= ST_HIGH;
            width_cnt  <= CNT_ONE;
            period_cnt <= CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (period_cnt == CNT_TIMEOUT) begin
            state      <= ST_IDLE;
            lost       <= 1'b1;
            width_cnt  <= '0;
            period_cnt <= '0;
          end else begin
            period_cnt <= period_cnt + CNT_ONE;
            if (fall_q) begin
              state <= ST_LOW;
            end else begin
              width_cnt <= width_cnt + CNT_ONE;
            end
          end
        end
        ST_LOW: begin
          if (period_cnt == CNT_TIMEOUT) begin
            state      <= ST_IDLE;
            lost       <= 1'b1;
            width_cnt  <= '0;
            period_cnt <= '0;
          end else if (rise_q) begin
            pending    <= 1'b1;
            width      <= width_cnt;
            period     <= period_cnt;
            lost       <= 1'b0;
            width_cnt  <= CNT_ONE;
            period_cnt <= CNT_ONE;
            state      <= ST_HIGH;
          end else begin
            period_cnt <= period_cnt + CNT_ONE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          width_cnt  <= '0;
          period_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_width_decoder.sv
// Multi-channel PWM width/period decoder: per-channel meters feeding a
// round-robin arbiter and a single registered valid/ready output slot.
module pwm_width_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH      = 6,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int unsigned CH_W       = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] pwm_in,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic [CH_W-1:0]   meas_ch,
  output logic [CNT_W-1:0]  meas_width,
  output logic [CNT_W-1:0]  meas_period,
  output logic [NUM_CH-1:0] ch_lost
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] take_c;
  logic [CNT_W-1:0]  pend_width  [NUM_CH];
  logic [CNT_W-1:0]  pend_period [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   idx_c;
  logic [CH_W-1:0]   grant_c;
  logic              grant_found_c;
  logic              load_c;

  // One meter per input line.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_width_meter #(
      .CNT_W       (CNT_W),
      .TIMEOUT     (TIMEOUT),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_meter (
      .clk     (clk),
      .reset   (reset),
      .pwm_in  (pwm_in[g]),
      .take    (take_c[g]),
      .pending (pend[g]),
      .width   (pend_width[g]),
      .period  (pend_period[g]),
      .lost    (ch_lost[g])
    );
  end

  // Slot may be refilled when empty or when its current result is accepted.
  assign load_c = ~meas_valid | meas_ready;

  // Round-robin search for the first pending channel at or after rr_ptr.
  always_comb begin
    grant_found_c = 1'b0;
    grant_c       = '0;
    idx_c         = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx_c = CH_W'((32'(rr_ptr) + i) % NUM_CH);
      if (!grant_found_c && pend[idx_c]) begin
        grant_found_c = 1'b1;
        grant_c       = idx_c;
      end
    end
  end

  assign take_c = (load_c && grant_found_c) ? (NUM_CH'(1) << grant_c) : '0;

  // Output slot and pointer; fields hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      meas_valid  <= 1'b0;
      meas_ch     <= '0;
      meas_width  <= '0;
      meas_period <= '0;
      rr_ptr      <= '0;
    end else if (load_c) begin
      meas_valid <= grant_found_c;
      if (grant_found_c) begin
        meas_ch     <= grant_c;
        meas_width  <= pend_width[grant_c];
        meas_period <= pend_period[grant_c];
        rr_ptr      <= (grant_c == CH_W'(NUM_CH - 1)) ? '0 : grant_c + CH_W'(1);
      end
    end
  end

endmodule
